// File: rtl/button_cmd_scheduler.sv
// Turns debounced button pulses into cursor moves and queued REVEAL/FLAG commands for the board engine.
// Latency: cursor updates one edge after the pulse; a command is visible at the queue head one edge after it is pushed.
// Backpressure: cmd_ready_i low holds the head; a push into a full queue with no pop is dropped and flagged on drop_o.

// Small synchronous FIFO with circular pointers and an occupancy count; DEPTH must be a power of two.
// Latency: a push at edge N is readable at the head from cycle N+1; the head is driven combinationally from storage.
// Backpressure: push_rdy_o is low only when full with no pop in the same cycle; flush_i empties it on the next edge.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    output logic         push_rdy_o,
    output logic         pop_vld_o,
    output logic [W-1:0] pop_dat_o,
    input  logic         pop_rdy_i
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    assign pop_vld_o  = (cnt_q != '0);
    assign pop_dat_o  = mem_q[rd_ptr_q];
    assign pop        = pop_vld_o & pop_rdy_i;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push_rdy_o = (cnt_q != CW'(DEPTH)) | pop;
    assign push       = push_vld_i & push_rdy_o;

    // Next-state for storage, pointers and count; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module button_cmd_scheduler #(
    parameter int          COLS    = 16,
    parameter int          ROWS    = 16,
    parameter int          XW      = 4,
    parameter int          YW      = 4,
    parameter logic [31:0] DBL_WIN = 32'd25_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    button_ac_i,
    input  logic          enable_i,
    output logic [XW-1:0] cursor_x_o,
    output logic [YW-1:0] cursor_y_o,
    output logic          cmd_valid_o,
    input  logic          cmd_ready_i,
    output logic          cmd_op_o,
    output logic [XW-1:0] cmd_x_o,
    output logic [YW-1:0] cmd_y_o,
    output logic          drop_o
);
    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

    typedef struct packed {
        logic          op;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [XW-1:0] cur_x_q, cur_x_d, pend_x_q, pend_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d, pend_y_q, pend_y_d;
    logic          drop_q, drop_d;

    logic act_up, act_dn, act_lt, act_rt, act_c, act_dir;
    logic push_vld, push_rdy, head_vld;
    cmd_t push_dat, head_dat;

    // One-hot priority decode: up > down > left > right > center, gated by enable.
    assign act_up  = enable_i & button_ac_i[0];
    assign act_dn  = enable_i & button_ac_i[1] & ~button_ac_i[0];
    assign act_lt  = enable_i & button_ac_i[2] & ~|button_ac_i[1:0];
    assign act_rt  = enable_i & button_ac_i[3] & ~|button_ac_i[2:0];
    assign act_c   = enable_i & button_ac_i[4] & ~|button_ac_i[3:0];
    assign act_dir = act_up | act_dn | act_lt | act_rt;

    // Cursor moves with wrap; the edge compare comes first so no arithmetic wraps.
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (act_up)      cur_y_d = (cur_y_q == '0)    ? Y_MAX : cur_y_q - YW'(1);
        else if (act_dn) cur_y_d = (cur_y_q == Y_MAX) ? '0    : cur_y_q + YW'(1);
        else if (act_lt) cur_x_d = (cur_x_q == '0)    ? X_MAX : cur_x_q - XW'(1);
        else if (act_rt) cur_x_d = (cur_x_q == X_MAX) ? '0    : cur_x_q + XW'(1);
    end

    // Click FSM: first center arms the window, second center inside it makes a FLAG.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        push_vld = 1'b0;
        push_dat = '{op: 1'b0, x: pend_x_q, y: pend_y_q};
        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (act_c) begin
                        pend_x_d = cur_x_q;
                        pend_y_d = cur_y_q;
                        cnt_d    = '0;
                        state_d  = WAIT2;
                    end
                end
                WAIT2: begin
                    if (act_c) begin
                        push_vld    = 1'b1;
                        push_dat.op = 1'b1;
                        state_d     = IDLE;
                    end else if (act_dir) begin
                        push_vld = 1'b1;
                        state_d  = IDLE;
                    end else if (cnt_q == DBL_WIN - 32'd1) begin
                        push_vld = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A push refused by the queue is reported as a one-cycle drop pulse.
    always_comb begin
        drop_d = push_vld & ~push_rdy;
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            drop_q   <= drop_d;
        end
    end

    sync_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (4)
    ) u_cmd_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (~enable_i),
        .push_vld_i (push_vld),
        .push_dat_i (push_dat),
        .push_rdy_o (push_rdy),
        .pop_vld_o  (head_vld),
        .pop_dat_o  (head_dat),
        .pop_rdy_i  (cmd_ready_i)
    );

    assign cursor_x_o  = cur_x_q;
    assign cursor_y_o  = cur_y_q;
    assign cmd_valid_o = head_vld;
    assign cmd_op_o    = head_dat.op;
    assign cmd_x_o     = head_dat.x;
    assign cmd_y_o     = head_dat.y;
    assign drop_o      = drop_q;
endmodule

// File: tb/tb_button_cmd_scheduler.sv
module tb_button_cmd_scheduler;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam logic [4:0] B_UP = 5'b00001;
    localparam logic [4:0] B_DN = 5'b00010;
    localparam logic [4:0] B_LT = 5'b00100;
    localparam logic [4:0] B_RT = 5'b01000;
    localparam logic [4:0] B_C  = 5'b10000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    btn;
    logic          en;
    logic          rdy;
    logic [XW-1:0] cur_x, cmd_x;
    logic [YW-1:0] cur_y, cmd_y;
    logic          cmd_valid, cmd_op, drop;

    int n_cmp = 0;
    int n_err = 0;

    button_cmd_scheduler #(
        .COLS    (16),
        .ROWS    (16),
        .XW      (XW),
        .YW      (YW),
        .DBL_WIN (32'd8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button_ac_i (btn),
        .enable_i    (en),
        .cursor_x_o  (cur_x),
        .cursor_y_o  (cur_y),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (rdy),
        .cmd_op_o    (cmd_op),
        .cmd_x_o     (cmd_x),
        .cmd_y_o     (cmd_y),
        .drop_o      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] b);
        btn = b;
        tick();
        btn = '0;
    endtask

    task automatic repeat_pulse(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) pulse(b);
    endtask

    // Counts cycles with cmd_valid high over n edges.
    task automatic count_valid(input int n, output int nv);
        nv = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cmd_valid) nv++;
        end
    endtask

    initial begin
        int first, nv;
        logic [XW-1:0] hx;
        logic [YW-1:0] hy;
        logic          hop;

        rst_n = 1'b0;
        en    = 1'b1;
        btn   = '0;
        rdy   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_cur_x", 32'(cur_x), 0);
        chk("rst_cur_y", 32'(cur_y), 0);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_op", 32'(cmd_op), 0);
        chk("rst_cmd_x", 32'(cmd_x), 0);
        chk("rst_cmd_y", 32'(cmd_y), 0);
        chk("rst_drop", 32'(drop), 0);

        // Wrap on left and up from origin
        repeat_pulse(B_LT, 3);
        pulse(B_UP);
        chk("wrap_x", 32'(cur_x), 13);
        chk("wrap_y", 32'(cur_y), 15);
        chk("wrap_no_cmd", 32'(cmd_valid), 0);

        // Move to (2,3): right 5 from 13, down 4 from 15
        repeat_pulse(B_RT, 5);
        repeat_pulse(B_DN, 4);
        chk("pos_x_2", 32'(cur_x), 2);
        chk("pos_y_3", 32'(cur_y), 3);

        // Single click times out into REVEAL 8 cycles later
        rdy = 1'b1;
        pulse(B_C);
        first = 0;
        nv    = 0;
        hx = '0; hy = '0; hop = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (cmd_valid) begin
                nv++;
                if (first == 0) begin
                    first = k;
                    hx = cmd_x; hy = cmd_y; hop = cmd_op;
                end
            end
        end
        chk("reveal_latency", 32'(first), 8);
        chk("reveal_vld_cycles", 32'(nv), 1);
        chk("reveal_op", 32'(hop), 0);
        chk("reveal_x", 32'(hx), 2);
        chk("reveal_y", 32'(hy), 3);

        // Double click 4 cycles apart gives one FLAG, no REVEAL
        pulse(B_C);
        tick();
        tick();
        tick();
        pulse(B_C);
        chk("flag_vld", 32'(cmd_valid), 1);
        chk("flag_op", 32'(cmd_op), 1);
        chk("flag_x", 32'(cmd_x), 2);
        chk("flag_y", 32'(cmd_y), 3);
        count_valid(14, nv);
        chk("flag_no_reveal", 32'(nv), 0);

        // Click at (5,5) then a move: REVEAL queued at once, cursor moves
        rdy = 1'b0;
        repeat_pulse(B_RT, 3);
        repeat_pulse(B_DN, 2);
        pulse(B_C);
        tick();
        pulse(B_RT);
        chk("mv_reveal_vld", 32'(cmd_valid), 1);
        chk("mv_reveal_op", 32'(cmd_op), 0);
        chk("mv_reveal_x", 32'(cmd_x), 5);
        chk("mv_reveal_y", 32'(cmd_y), 5);
        chk("mv_cur_x", 32'(cur_x), 6);
        chk("mv_cur_y", 32'(cur_y), 5);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("mv_drained", 32'(cmd_valid), 0);

        // Fill the queue: 5 REVEALs at x=6..10, the fifth is dropped
        for (int i = 0; i < 5; i++) begin
            pulse(B_C);
            pulse(B_RT);
            chk($sformatf("fill_drop_%0d", i), 32'(drop), (i == 4) ? 1 : 0);
        end
        tick();
        chk("drop_one_cycle", 32'(drop), 0);
        chk("full_vld", 32'(cmd_valid), 1);
        chk("hold_head_x", 32'(cmd_x), 6);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop%0d_vld", i), 32'(cmd_valid), 1);
            chk($sformatf("pop%0d_x", i), 32'(cmd_x), 6 + i);
            chk($sformatf("pop%0d_y", i), 32'(cmd_y), 5);
            chk($sformatf("pop%0d_op", i), 32'(cmd_op), 0);
            tick();
        end
        chk("pop_empty", 32'(cmd_valid), 0);
        rdy = 1'b0;

        // Up and center together: only the move happens
        pulse(B_UP | B_C);
        chk("prio_cur_x", 32'(cur_x), 11);
        chk("prio_cur_y", 32'(cur_y), 4);
        count_valid(12, nv);
        chk("prio_no_click", 32'(nv), 0);

        // Two queued, pending click, then enable low flushes everything
        pulse(B_C);
        pulse(B_RT);
        pulse(B_C);
        pulse(B_RT);
        chk("q2_vld", 32'(cmd_valid), 1);
        pulse(B_C);
        tick();
        en  = 1'b0;
        btn = B_LT;
        tick();
        btn = '0;
        chk("dis_flush_vld", 32'(cmd_valid), 0);
        chk("dis_cur_x", 32'(cur_x), 13);
        chk("dis_cur_y", 32'(cur_y), 4);
        en  = 1'b1;
        rdy = 1'b1;
        count_valid(14, nv);
        chk("dis_no_late_reveal", 32'(nv), 0);
        chk("dis_cur_x_after", 32'(cur_x), 13);

        // Reset mid-operation clears queue and cursor
        rdy = 1'b0;
        pulse(B_C);
        pulse(B_RT);
        chk("pre_rst_vld", 32'(cmd_valid), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_vld", 32'(cmd_valid), 0);
        chk("midrst_cur_x", 32'(cur_x), 0);
        chk("midrst_cur_y", 32'(cur_y), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/button_cmd_scheduler.md
Name: button_cmd_scheduler

Overview:
Sits between button_process and the minesweeper board engine. It consumes the one-cycle, debounced button pulses and maintains the cursor position, wrapping at the board edges. A center click becomes REVEAL and a double center click becomes FLAG. Commands are queued in a 4-entry FIFO and issued to the board engine over a valid/ready handshake.

Parameters:
COLS, 16, board width in cells (2..2^XW)
ROWS, 16, board height in cells (2..2^YW)
XW, 4, cursor X width
YW, 4, cursor Y width
DBL_WIN, 32'd25_000_000, double-click window in clk cycles (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
button_ac_i  in  5  one-cycle pulses from debouncer; bit0 up, bit1 down, bit2 left, bit3 right, bit4 center
enable_i  in  1  game accepting input; low = ignore buttons, flush pending
cursor_x_o  out  XW  current cursor column
cursor_y_o  out  YW  current cursor row
cmd_valid_o  out  1  FIFO head valid
cmd_ready_i  in  1  board engine accepts head this cycle
cmd_op_o  out  1  0 = REVEAL, 1 = FLAG
cmd_x_o  out  XW  head command column
cmd_y_o  out  YW  head command row
drop_o  out  1  one-cycle pulse: command lost because FIFO full

Behaviour:
- Clocking and reset: all state updates on posedge clk. Reset is synchronous and active-low; it is sampled only on the clock edge.
- Reset values:
  - cursor_x_o = 0, cursor_y_o = 0
  - FIFO empty: cmd_valid_o = 0, cmd_op_o = 0, cmd_x_o = 0, cmd_y_o = 0
  - drop_o = 0
  - FSM = IDLE, window counter = 0
- Button decode (only when enable_i = 1):
  - If several bits are set in one cycle, only the highest-priority bit acts: up > down > left > right > center. The others are dropped silently.
- Cursor moves take effect at the next edge:
  - up: y = (y == 0) ? ROWS-1 : y-1
  - down: y = (y == ROWS-1) ? 0 : y+1
  - left and right: same rule on x with COLS
- Click FSM, states IDLE and WAIT2:
  - IDLE + center → latch (cursor_x, cursor_y) into pend_x and pend_y; counter = 0; go to WAIT2.
  - WAIT2, checked in this order each cycle:
    1. center pulse → push FLAG(pend) and go to IDLE.
    2. direction pulse → push REVEAL(pend); apply the cursor move in the same cycle; go to IDLE.
    3. counter == DBL_WIN-1 → push REVEAL(pend) and go to IDLE.
    4. Otherwise counter++.
  - A center pulse in WAIT2 on the same cycle the counter expires counts as FLAG.
- FIFO:
  - 4 entries of {op, x, y}; circular pointers plus count, no bubbles.
  - Head is presented combinationally from storage. cmd_valid_o = (count != 0).
  - Pop occurs when cmd_valid_o & cmd_ready_i.
  - Push latency: a command pushed at edge N is visible at the head from cycle N+1 when the FIFO was empty.
  - Push when full with no simultaneous pop: the entry is discarded, drop_o = 1 for one cycle, and the FIFO is unchanged.
  - Push when full with a simultaneous pop: both occur, count stays 4, and no drop.
  - Push and pop together at any other count: count unchanged.
  - Head fields hold stable while cmd_valid_o = 1 and cmd_ready_i = 0.
- enable_i = 0:
  - All button pulses are ignored.
  - The FSM is forced to IDLE; a pending click is discarded with no push.
  - The FIFO is flushed; cmd_valid_o = 0 from the next cycle.
  - The cursor position is retained.
- Reset mid-operation: reset overrides every condition in the same edge; pending clicks and queued commands are lost.
- Widths: the counter is 32 bits. There is no arithmetic overflow, because the cursor compare precedes every increment or decrement.

Test Plan:
- All five scenarios use COLS = ROWS = 16 and DBL_WIN = 8.
- Reset then 3× left pulses, 1× up pulse → cursor = (13, 15); cmd_valid_o stays 0.
- Cursor at (2, 3); one center pulse; cmd_ready_i = 1 → exactly 8 cycles after the pulse a REVEAL(2, 3) appears with cmd_valid_o high for 1 cycle.
- Center pulse, then a second center pulse 4 cycles later → single FLAG(2, 3) issued the cycle after the second pulse; no REVEAL.
- Center at (5, 5), then right pulse 2 cycles later → REVEAL(5, 5) queued immediately; cursor = (6, 5).
- cmd_ready_i = 0; generate 5 REVEALs → count = 4, drop_o pulses once on the 5th push. Raise cmd_ready_i → heads pop in order with the 4 original coordinates.
- Mixed cases:
  - up and center asserted together → only the up move occurs.
  - enable_i low during WAIT2 with 2 entries queued → cmd_valid_o = 0 next cycle and no later REVEAL; cursor unchanged.
